fp64_mem_sequencer: RTL
=======================

// Module: fp64_mem_sequencer
// PURPOSE
// - Sequences the second (high-word) 32-bit access of FLD/FSD on the 32-bit data bus.
// - Low word goes through the normal EX path. This block owns the FP64 override inputs of
//   the data memory arbiter (override/address/write data/byte enables), stalls the pipeline
//   and assembles the 64-bit FLD result.
// PARAMETERS
// - XLEN            32  address/data width (fixed 32 for FP64 split)
// - MEM_RD_LATENCY  1   cycles from read request to i_mem_rd_data valid; legal 1..3
// PORTS
// - i_clk                       in   1     clock, all logic rising-edge
// - i_rst_n                     in   1     reset, synchronous, active-low
// - i_fld_start                 in   1     FLD in MA, low word data present this cycle
// - i_fsd_start                 in   1     FSD in MA, low word written this cycle
// - i_address                   in   XLEN  FLD/FSD base (low-word) address
// - i_fld_lo_data               in   32    FLD low word read data
// - i_fsd_hi_data               in   32    FSD high word store data
// - i_mem_rd_data               in   32    data memory read data
// - i_flush                     in   1     pipeline flush/trap, abort sequence
// - o_fp_mem_addr_override      out  1     to arbiter: drive bus from this block
// - o_fp_mem_address            out  XLEN  base+4
// - o_fp_mem_write_data         out  32    high store word
// - o_fp_mem_byte_write_enable  out  4     4'b1111 in FSD write cycle, else 0
// - o_fp_mem_stall              out  1     hold pipeline
// - o_fld_data                  out  64    {hi, lo} FLD result
// - o_fld_valid                 out  1     one-cycle result strobe
// - o_misaligned                out  1     misaligned FP64 access (macro only, else 0)
// BEHAVIOUR
// - Reset: state IDLE, counter 0, every output 0 (o_fld_data 64'h0). Reset mid-sequence
//   aborts with no further bus activity.
// - States: IDLE, FLD_REQ, FLD_WAIT, FLD_DONE, FSD_WR.
// - IDLE: start accepted only here.
//   - Start cycle T: o_fp_mem_stall=1 (combinational).
//   - Registers hi_addr=i_address+4 (mod 2^XLEN, wraps) and lo data/hi store data.
//   - Next state FLD_REQ or FSD_WR.
// - Start arbitration: both starts high -> FLD wins, FSD dropped. Start while not IDLE ignored.
// - FLD_REQ (T+1): override=1, address=hi_addr, byte_we=0 (arbiter issues read).
//   Counter loads MEM_RD_LATENCY-1. Next FLD_WAIT.
// - FLD_WAIT: override=0.
//   - Counter 0: capture i_mem_rd_data as hi word -> FLD_DONE.
//   - Otherwise decrement.
// - FLD_DONE: o_fld_valid=1, o_fld_data={hi,lo}, stall=0 -> IDLE.
//   Total stall = 2+MEM_RD_LATENCY cycles.
// - FSD_WR (T+1): override=1, address=hi_addr, write_data=hi, byte_we=4'b1111,
//   stall=1 -> IDLE. Stall = 2 cycles.
// - o_fp_mem_stall=1 in every non-IDLE state except FLD_DONE.
// - Override/we/address are registered-state decodes only, with no path from i_* starts.
// - i_flush in any state:
//   - Next state IDLE.
//   - Same-cycle byte_we forced 0 and override forced 0.
//   - No o_fld_valid for the aborted op.
//   - Flush in the start cycle cancels the start.
// - o_fld_data holds its last value when o_fld_valid=0.
// CONFIGURATION
// - FP64_MISALIGN_TRAP_EN defined:
//   - Start with i_address[2:0]!=0 is not sequenced; state stays IDLE.
//   - o_misaligned=1 for that cycle; stall=0.
// - FP64_MISALIGN_TRAP_EN undefined:
//   - o_misaligned tied 0.
//   - Any word-aligned address is sequenced as-is, including +4 wrap at 0xFFFF_FFFC->0x0.
// TESTING
// - FLD @0x1000, lo=0x89ABCDEF, mem returns 0x01234567 at T+2 (L=1):
//   override at T+1 addr 0x1004; stall T..T+2; T+3 valid, data 0x0123456789ABCDEF.
// - FSD @0x2000, hi=0xDEADBEEF: T+1 override, addr 0x2004, we=1111, wdata 0xDEADBEEF;
//   stall T..T+1; no o_fld_valid.
// - FLD+FSD same cycle, then start during FLD_WAIT: only FLD runs, no write, later start ignored.
// - i_flush in FSD_WR: byte_we=0 that cycle, IDLE next.
//   Reset (i_rst_n=0) in FLD_WAIT: all outputs 0 next cycle.
// - MEM_RD_LATENCY=3: capture at T+4, valid T+5; addr 0xFFFFFFFC -> hi addr 0x00000000.
// - Macro on: FLD @0x1004 -> o_misaligned=1 one cycle, no override, no stall.
//   Macro off: same access sequenced normally.

Source files
------------

// File: rtl/fp64_mem_sequencer.sv
// Sequences the high-word access of FLD/FSD on a 32-bit data bus and assembles the FLD result.
// Optional macro FP64_MISALIGN_TRAP_EN: refuse starts with i_address[2:0] != 0 and flag them.
module fp64_mem_sequencer #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned MEM_RD_LATENCY = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_fld_start,
    input  logic            i_fsd_start,
    input  logic [XLEN-1:0] i_address,
    input  logic [31:0]     i_fld_lo_data,
    input  logic [31:0]     i_fsd_hi_data,
    input  logic [31:0]     i_mem_rd_data,
    input  logic            i_flush,
    output logic            o_fp_mem_addr_override,
    output logic [XLEN-1:0] o_fp_mem_address,
    output logic [31:0]     o_fp_mem_write_data,
    output logic [3:0]      o_fp_mem_byte_write_enable,
    output logic            o_fp_mem_stall,
    output logic [63:0]     o_fld_data,
    output logic            o_fld_valid,
    output logic            o_misaligned
);

    typedef enum logic [2:0] {
        StIdle,
        StFldReq,
        StFldWait,
        StFldDone,
        StFsdWr
    } state_e;

    localparam logic [1:0] CntInit = 2'(MEM_RD_LATENCY - 1);

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] hi_addr_q, hi_addr_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     hi_store_q, hi_store_d;
    logic [31:0]     hi_word_q, hi_word_d;
    logic [63:0]     fld_data_q, fld_data_d;
    logic            start_req;
    logic            misalign;

    assign start_req = i_fld_start | i_fsd_start;

`ifdef FP64_MISALIGN_TRAP_EN
    assign misalign = start_req && (i_address[2:0] != 3'b000);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_addr_d  = hi_addr_q;
        lo_d       = lo_q;
        hi_store_d = hi_store_q;
        hi_word_d  = hi_word_q;
        fld_data_d = fld_data_q;

        o_fp_mem_addr_override     = 1'b0;
        o_fp_mem_address           = '0;
        o_fp_mem_write_data        = 32'h0;
        o_fp_mem_byte_write_enable = 4'b0000;
        o_fp_mem_stall             = 1'b0;
        o_fld_valid                = 1'b0;
        o_misaligned               = 1'b0;

        unique case (state_q)
            StIdle: begin
                o_misaligned = misalign && !i_flush;
                if (start_req && !i_flush && !misalign) begin
                    o_fp_mem_stall = 1'b1;
                    hi_addr_d      = i_address + XLEN'(4);
                    lo_d           = i_fld_lo_data;
                    hi_store_d     = i_fsd_hi_data;
                    // FLD has priority; a simultaneous FSD is dropped.
                    state_d        = i_fld_start ? StFldReq : StFsdWr;
                end
            end
            StFldReq: begin
                o_fp_mem_addr_override = 1'b1;
                o_fp_mem_address       = hi_addr_q;
                o_fp_mem_stall         = 1'b1;
                cnt_d                  = CntInit;
                state_d                = StFldWait;
            end
            StFldWait: begin
                o_fp_mem_stall = 1'b1;
                if (cnt_q == 2'd0) begin
                    hi_word_d = i_mem_rd_data;
                    state_d   = StFldDone;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StFldDone: begin
                o_fld_valid = 1'b1;
                fld_data_d  = {hi_word_q, lo_q};
                state_d     = StIdle;
            end
            StFsdWr: begin
                o_fp_mem_addr_override     = 1'b1;
                o_fp_mem_address           = hi_addr_q;
                o_fp_mem_write_data        = hi_store_q;
                o_fp_mem_byte_write_enable = 4'b1111;
                o_fp_mem_stall             = 1'b1;
                state_d                    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush kills any bus activity and result of the current op this same cycle.
        if (i_flush) begin
            state_d                    = StIdle;
            o_fp_mem_addr_override     = 1'b0;
            o_fp_mem_byte_write_enable = 4'b0000;
            o_fld_valid                = 1'b0;
            fld_data_d                 = fld_data_q;
        end

        o_fld_data = fld_data_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            hi_addr_q  <= '0;
            lo_q       <= 32'h0;
            hi_store_q <= 32'h0;
            hi_word_q  <= 32'h0;
            fld_data_q <= 64'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_addr_q  <= hi_addr_d;
            lo_q       <= lo_d;
            hi_store_q <= hi_store_d;
            hi_word_q  <= hi_word_d;
            fld_data_q <= fld_data_d;
        end
    end

endmodule
